// File: rtl/framer.sv
// Async-serial frame builder: start bit, 7/8 data bits LSB first,
// optional parity, 1/2 stop bits, idle-padded to 11 bits.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   tx_en        0 forces the idle frame
//   din          data word, din[0] sent first
//   parity_bit   external parity bit, inserted verbatim
//   data_length  0: 7 data bits, 1: 8 data bits
//   parity_type  00 none, 01 odd, 10 even, 11 none
//   stop_bits    0: one stop bit, 1: two stop bits
//   frame        registered frame, frame[0] first on the line
//   frame_bits   registered count of meaningful bits (0 when idle)
//   parity_err   registered parity_bit vs computed parity mismatch
module framer (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic [7:0]  din,
    input  logic        parity_bit,
    input  logic        data_length,
    input  logic [1:0]  parity_type,
    input  logic        stop_bits,
    output logic [10:0] frame,
    output logic [3:0]  frame_bits,
    output logic        parity_err
);

    localparam logic [10:0] IDLE = 11'h7FF;

    logic        par_en;
    logic        data_xor;
    logic        par_calc;
    logic [3:0]  par_pos;
    logic [3:0]  bits_raw;
    logic [11:0] full;
    logic [10:0] frame_d;
    logic [3:0]  bits_d;
    logic        err_d;

    assign par_en = (parity_type == 2'b01) || (parity_type == 2'b10);

    // XOR of the selected data bits; bit 7 only counts in 8-bit mode.
    assign data_xor = (^din[6:0]) ^ (data_length & din[7]);

    // Odd parity sets the bit when the data holds an even count of ones.
    assign par_calc = (parity_type == 2'b01) ? ~data_xor : data_xor;

    // Parity sits right after the last data bit.
    assign par_pos = data_length ? 4'd9 : 4'd8;

    assign bits_raw = 4'd1
                    + (data_length ? 4'd8 : 4'd7)
                    + {3'b000, par_en}
                    + (stop_bits ? 4'd2 : 4'd1);

    // Build a 12-bit line image pre-filled with ones so stop bits and
    // idle padding come for free; bit 11 is the truncated second stop.
    always_comb begin
        full    = '1;
        full[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 7 || data_length) begin
                full[i+1] = din[i];
            end
        end
        if (par_en) begin
            full[par_pos] = parity_bit;
        end
    end

    always_comb begin
        frame_d = full[10:0];
        bits_d  = (bits_raw > 4'd11) ? 4'd11 : bits_raw;
        err_d   = par_en && (parity_bit != par_calc);
        if (!tx_en) begin
            frame_d = IDLE;
            bits_d  = 4'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame      <= IDLE;
            frame_bits <= 4'd0;
            parity_err <= 1'b0;
        end else begin
            frame      <= frame_d;
            frame_bits <= bits_d;
            parity_err <= err_d;
        end
    end

endmodule

// File: tb/tb_framer.sv
// Self-checking bench for framer: queue-based frame model checked
// every cycle, plus hand-computed literal vectors.
module tb_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [7:0]  din;
    logic        parity_bit;
    logic        data_length;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic [10:0] frame;
    logic [3:0]  frame_bits;
    logic        parity_err;

    int checks = 0;
    int errors = 0;

    logic [10:0] xf;
    logic [3:0]  xb;
    logic        xe;
    bit          have = 0;

    framer dut (
        .clk(clk),
        .rst(rst),
        .tx_en(tx_en),
        .din(din),
        .parity_bit(parity_bit),
        .data_length(data_length),
        .parity_type(parity_type),
        .stop_bits(stop_bits),
        .frame(frame),
        .frame_bits(frame_bits),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [10:0] a,
                       input logic [10:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // Line-level model: push bits in transmit order, then truncate/pad.
    function automatic void model(
        input logic r, input logic en, input logic [7:0] d,
        input logic pb, input logic dl, input logic [1:0] pt,
        input logic sb, output logic [10:0] ef,
        output logic [3:0] eb, output logic ee);
        bit q[$];
        int n;
        int ones;
        bit want;
        ef = '1;
        eb = 4'd0;
        ee = 1'b0;
        if (r || !en) return;
        q.push_back(1'b0);
        n = dl ? 8 : 7;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pt == 2'b01 || pt == 2'b10) begin
            if (pt == 2'b01) want = (ones % 2 == 0);
            else             want = (ones % 2 == 1);
            q.push_back(pb);
            ee = (pb != want);
        end
        q.push_back(1'b1);
        if (sb) q.push_back(1'b1);
        eb = (q.size() > 11) ? 4'd11 : 4'(q.size());
        for (int i = 0; i < 11 && i < q.size(); i++) ef[i] = q[i];
    endfunction

    always @(posedge clk) begin
        model(rst, tx_en, din, parity_bit, data_length, parity_type,
              stop_bits, xf, xb, xe);
        have = 1;
    end

    always @(negedge clk) begin
        if (have) begin
            chk("mdl_frame", frame, xf);
            chk("mdl_bits", {7'd0, frame_bits}, {7'd0, xb});
            chk("mdl_err", {10'd0, parity_err}, {10'd0, xe});
        end
    end

    task automatic drive(input logic r, input logic en,
                         input logic [7:0] d, input logic pb,
                         input logic dl, input logic [1:0] pt,
                         input logic sb);
        @(negedge clk);
        rst = r;
        tx_en = en;
        din = d;
        parity_bit = pb;
        data_length = dl;
        parity_type = pt;
        stop_bits = sb;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [10:0] ef,
                       input logic [3:0] eb, input logic ee);
        chk({nm, "_frame"}, frame, ef);
        chk({nm, "_bits"}, {7'd0, frame_bits}, {7'd0, eb});
        chk({nm, "_err"}, {10'd0, parity_err}, {10'd0, ee});
    endtask

    initial begin
        rst = 1'b1;
        tx_en = 1'b1;
        din = 8'h00;
        parity_bit = 1'b0;
        data_length = 1'b0;
        parity_type = 2'b00;
        stop_bits = 1'b0;

        drive(1, 1, 8'hAB, 1, 1, 2'b01, 1);
        lit("reset", 11'h7FF, 4'd0, 1'b0);

        drive(0, 1, 8'hAB, 1, 0, 2'b01, 1);
        lit("d7_odd_s2", 11'h756, 4'd11, 1'b0);
        drive(0, 1, 8'hAB, 0, 0, 2'b10, 1);
        lit("d7_even_s2", 11'h656, 4'd11, 1'b0);

        drive(0, 1, 8'hAB, 0, 1, 2'b01, 0);
        lit("d8_odd_s1", 11'h556, 4'd11, 1'b0);
        drive(0, 1, 8'hAB, 1, 1, 2'b10, 0);
        lit("d8_even_s1", 11'h756, 4'd11, 1'b0);
        drive(0, 1, 8'hAB, 1, 1, 2'b01, 0);
        lit("d8_odd_perr", 11'h756, 4'd11, 1'b1);

        drive(0, 1, 8'h6D, 0, 1, 2'b00, 0);
        lit("np_d8_s1", 11'h6DA, 4'd10, 1'b0);
        drive(0, 1, 8'h6D, 1, 0, 2'b00, 1);
        lit("np_d7_s2", 11'h7DA, 4'd10, 1'b0);
        drive(0, 1, 8'h6D, 1, 1, 2'b11, 0);
        lit("rsv_d8_s1", 11'h6DA, 4'd10, 1'b0);
        drive(0, 1, 8'h6D, 0, 0, 2'b11, 1);
        lit("rsv_d7_s2", 11'h7DA, 4'd10, 1'b0);

        drive(0, 1, 8'h00, 1, 0, 2'b01, 1);
        lit("zero_odd", 11'h700, 4'd11, 1'b0);

        drive(0, 1, 8'hAB, 1, 1, 2'b10, 1);
        lit("trunc", 11'h756, 4'd11, 1'b0);
        chk("trunc_bit10", {10'd0, frame[10]}, 11'd1);

        drive(0, 1, 8'h6D, 0, 1, 2'b00, 0);
        lit("pre_rst", 11'h6DA, 4'd10, 1'b0);
        drive(1, 1, 8'h6D, 0, 1, 2'b00, 0);
        lit("mid_rst", 11'h7FF, 4'd0, 1'b0);
        drive(0, 1, 8'h6D, 0, 1, 2'b00, 0);
        lit("post_rst", 11'h6DA, 4'd10, 1'b0);
        drive(0, 0, 8'h6D, 0, 1, 2'b00, 0);
        lit("txen_off", 11'h7FF, 4'd0, 1'b0);
        drive(0, 1, 8'h6D, 0, 1, 2'b00, 0);
        lit("txen_on", 11'h6DA, 4'd10, 1'b0);
        drive(0, 0, 8'hAB, 1, 1, 2'b01, 0);
        lit("txen_off_perr", 11'h7FF, 4'd0, 1'b0);

        foreach (sweep_din[k]) begin
            for (int c = 0; c < 32; c++) begin
                drive(0, 1, sweep_din[k], c[0], c[1], c[3:2], c[4]);
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    logic [7:0] sweep_din [4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};

endmodule
